// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: word-address PC, instruction word and fetch-queue entry.
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 12;
   localparam int unsigned INSTR_W      = 32;

   typedef logic [FETCH_ADDR_W-1:0] Fetch_addr;
   typedef logic [INSTR_W-1:0]      Instr_word;

   typedef struct packed {
      Fetch_addr pc;
      Instr_word instr;
      logic      pred_taken;
      Fetch_addr pred_target;
   } Fetch_entry;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between F2 and decode; pointers carry an extra wrap bit for full/empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned depth = 4,
   localparam int unsigned ptr_w = $clog2(depth)
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic         enq,
   input  Fetch_entry   enq_data,
   input  logic         deq,
   input  logic         flush,
   output logic [ptr_w:0] count,
   output Fetch_entry   head
);

   localparam logic [ptr_w:0] ptr_one  = 1;
   localparam logic [ptr_w:0] full_cnt = depth[ptr_w:0];

   logic [ptr_w:0] wr_q, rd_q;
   Fetch_entry     mem_q [depth];

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (enq) wr_q <= wr_q + ptr_one;
         if (deq) rd_q <= rd_q + ptr_one;
      end
   end

   always_ff @(posedge clk) begin
      if (enq && !flush) mem_q[wr_q[ptr_w-1:0]] <= enq_data;
   end

   assign count = wr_q - rd_q;
   assign head  = mem_q[rd_q[ptr_w-1:0]];

   // Upstream credit check must make this impossible.
   assert property (@(posedge clk) disable iff (!resetb) !(enq && !flush && count == full_cnt));

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch next-PC generator: F1 lookup/issue, F2 capture with taken-branch kill, queue to decode.
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int unsigned addr_width = FETCH_ADDR_W,
   parameter int unsigned instr_width = INSTR_W,
   parameter int unsigned fq_depth = 4,
   parameter logic [addr_width-1:0] boot_addr = '0
) (
   input  logic                   clk,
   input  logic                   resetb,
   output logic [addr_width-1:0]  bc_addr,
   input  logic                   bc_predict_taken,
   input  logic [addr_width-1:0]  bc_predict_target,
   output logic                   imem_req,
   output logic [addr_width-1:0]  imem_addr,
   input  logic [instr_width-1:0] imem_data,
   input  logic                   redirect,
   input  logic [addr_width-1:0]  redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [addr_width-1:0]  out_pc,
   output logic [instr_width-1:0] out_instr,
   output logic                   out_pred_taken,
   output logic [addr_width-1:0]  out_pred_target
);

   localparam int unsigned cnt_w = $clog2(fq_depth) + 1;
   localparam logic [cnt_w:0] depth_lim = fq_depth[cnt_w:0];
   localparam logic [addr_width-1:0] pc_one = 1;

   logic [addr_width-1:0] pc_q, f2_pc_q;
   logic                  f1_valid_q, f2_valid_q;
   logic [cnt_w-1:0]      fq_count;
   logic [cnt_w:0]        credit_used;
   logic                  issue, kill, enq, deq;
   Fetch_entry            enq_entry, head;

   // In-flight F2 reserves a slot; a same-cycle dequeue does not.
   assign credit_used = {1'b0, fq_count} + {{cnt_w{1'b0}}, f2_valid_q};
   assign issue = f1_valid_q && !redirect && (credit_used < depth_lim);
   assign kill  = f2_valid_q && bc_predict_taken;
   assign enq   = f2_valid_q && !redirect;
   assign deq   = out_valid && out_ready;

   assign enq_entry = '{pc: f2_pc_q, instr: imem_data, pred_taken: bc_predict_taken,
                        pred_target: bc_predict_target};

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pc_q       <= boot_addr;
         f2_pc_q    <= '0;
         f1_valid_q <= 1'b0;
         f2_valid_q <= 1'b0;
      end else begin
         f1_valid_q <= 1'b1;
         f2_valid_q <= issue && !kill;
         f2_pc_q    <= pc_q;
         if (redirect)   pc_q <= redirect_pc;
         else if (kill)  pc_q <= bc_predict_target;
         else if (issue) pc_q <= pc_q + pc_one;
      end
   end

   fetch_queue #(
      .depth (fq_depth)
   ) u_queue (
      .clk      (clk),
      .resetb   (resetb),
      .enq      (enq),
      .enq_data (enq_entry),
      .deq      (deq),
      .flush    (redirect),
      .count    (fq_count),
      .head     (head)
   );

   assign bc_addr   = pc_q;
   assign imem_addr = pc_q;
   assign imem_req  = issue;

   assign out_valid       = (fq_count != '0);
   assign out_pc          = out_valid ? head.pc : '0;
   assign out_instr       = out_valid ? head.instr : '0;
   assign out_pred_taken  = out_valid && head.pred_taken;
   assign out_pred_target = out_valid ? head.pred_target : '0;

   assert property (@(posedge clk) disable iff (!resetb)
      out_valid && !out_ready && !redirect |=> out_pc == $past(out_pc));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a one-entry branch cache and address-tagged memory model.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        resetb;
   logic [11:0] bc_addr, imem_addr, redirect_pc, out_pc, out_pred_target, bc_predict_target;
   logic        bc_predict_taken, imem_req, redirect, out_valid, out_ready, out_pred_taken;
   logic [31:0] imem_data, out_instr;

   int nvec = 0;
   int nmis = 0;

   fetch_pc_gen #(
      .boot_addr (12'h010)
   ) dut (
      .clk               (clk),
      .resetb            (resetb),
      .bc_addr           (bc_addr),
      .bc_predict_taken  (bc_predict_taken),
      .bc_predict_target (bc_predict_target),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_data         (imem_data),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_pc            (out_pc),
      .out_instr         (out_instr),
      .out_pred_taken    (out_pred_taken),
      .out_pred_target   (out_pred_target)
   );

   always #5 clk = ~clk;

   // Advance one cycle; cache and memory answer for the address presented during that cycle.
   task automatic tick();
      logic [11:0] a;
      a = bc_addr;
      @(posedge clk);
      #1;
      bc_predict_taken  = (a == 12'h014);
      bc_predict_target = (a == 12'h014) ? 12'h100 : 12'h000;
      imem_data         = {20'hC0DE0, a};
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic head(input string tag, input logic [11:0] pc);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_pc"}, {20'd0, out_pc}, {20'd0, pc});
      chk({tag, "_instr"}, out_instr, {20'hC0DE0, pc});
   endtask

   initial begin
      resetb = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b1;
      bc_predict_taken = 1'b0;
      bc_predict_target = '0;
      imem_data = '0;
      #2;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_bc_addr", {20'd0, bc_addr}, 32'h010);
      chk("rst_imem_addr", {20'd0, imem_addr}, 32'h010);
      chk("rst_out_pc", {20'd0, out_pc}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);

      resetb = 1'b1;
      tick();
      chk("e1_out_valid", {31'd0, out_valid}, 32'd0);
      chk("e1_imem_req", {31'd0, imem_req}, 32'd1);
      chk("e1_bc_addr", {20'd0, bc_addr}, 32'h010);
      tick();
      chk("e2_out_valid", {31'd0, out_valid}, 32'd0);
      chk("e2_bc_addr", {20'd0, bc_addr}, 32'h011);
      for (int k = 0; k < 4; k++) begin
         tick();
         head("seq", 12'h010 + 12'(k));
         chk("seq_pred", {31'd0, out_pred_taken}, 32'd0);
      end

      tick();
      head("br", 12'h014);
      chk("br_pred_taken", {31'd0, out_pred_taken}, 32'd1);
      chk("br_pred_target", {20'd0, out_pred_target}, 32'h100);
      tick();
      chk("br_bubble", {31'd0, out_valid}, 32'd0);
      tick();
      head("tgt0", 12'h100);
      chk("tgt0_pred", {31'd0, out_pred_taken}, 32'd0);
      tick();
      head("tgt1", 12'h101);

      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         head("stall", 12'h101);
         if (i >= 1) chk("stall_imem_req", {31'd0, imem_req}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("release_no_issue", {31'd0, imem_req}, 32'd0);
      tick();
      head("resume0", 12'h102);
      chk("resume_imem_req", {31'd0, imem_req}, 32'd1);
      chk("resume_addr", {20'd0, imem_addr}, 32'h105);
      for (int k = 1; k < 5; k++) begin
         tick();
         head("resume", 12'h102 + 12'(k));
      end

      out_ready = 1'b0;
      tick();
      head("pre_redir", 12'h106);
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 12'h2A0;
      #1;
      chk("redir_imem_req", {31'd0, imem_req}, 32'd0);
      tick();
      redirect = 1'b0;
      chk("redir_flush", {31'd0, out_valid}, 32'd0);
      chk("redir_bc_addr", {20'd0, bc_addr}, 32'h2A0);
      tick();
      chk("redir_lat", {31'd0, out_valid}, 32'd0);
      tick();
      head("redir0", 12'h2A0);
      tick();
      head("redir1", 12'h2A1);

      redirect = 1'b1;
      redirect_pc = 12'hFFE;
      tick();
      redirect = 1'b0;
      chk("wrap_flush", {31'd0, out_valid}, 32'd0);
      tick();
      chk("wrap_addr_fff", {20'd0, bc_addr}, 32'hFFF);
      tick();
      head("wrap0", 12'hFFE);
      chk("wrap_addr_000", {20'd0, bc_addr}, 32'h000);
      tick();
      head("wrap1", 12'hFFF);
      tick();
      head("wrap2", 12'h000);

      out_ready = 1'b0;
      repeat (6) tick();
      head("full", 12'h000);
      chk("full_imem_req", {31'd0, imem_req}, 32'd0);
      resetb = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_bc_addr", {20'd0, bc_addr}, 32'h010);
      chk("mid_rst_out_pc", {20'd0, out_pc}, 32'd0);
      tick();
      resetb = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("reboot_valid", {31'd0, out_valid}, 32'd0);
      chk("reboot_imem_req", {31'd0, imem_req}, 32'd1);
      tick();
      tick();
      head("reboot0", 12'h010);
      tick();
      head("reboot1", 12'h011);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
